// File: rtl/keypad_emulator.sv
// keypad_emulator: presses queued key indices onto a 4x4 matrix by answering column strobes.
// Define KEYPAD_EMULATOR_FIFO_EN for a FIFO_DEPTH-entry key queue; otherwise a single-entry buffer.
module keypad_emulator #(
  parameter int HOLD_CYCLES = 1024,
  parameter int GAP_CYCLES  = 1024,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] COL,
  output logic [3:0] ROW,
  input  logic [3:0] KEY_IN,
  input  logic       KEY_IN_VALID,
  output logic       KEY_IN_READY,
  output logic       BUSY,
  output logic       PRESS_DONE
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

`ifdef KEYPAD_EMULATOR_FIFO_EN
  localparam int QD = FIFO_DEPTH;
`else
  // Single-entry buffer: FIFO_DEPTH has no effect in this build.
  localparam int QD = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
  localparam int PW = (QD > 1) ? $clog2(QD) : 1;
  localparam int CW = $clog2(QD + 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  state_t        state, state_nxt;
  logic [15:0]   cnt, cnt_nxt;
  logic          done_nxt;
  logic          pop, push, full, empty;
  logic [3:0]    held, row_nxt;
  logic [3:0]    mem [QD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == CW'(QD));
  assign empty        = (count == '0);
  assign push         = KEY_IN_VALID && !full;
  assign KEY_IN_READY = !full;
  assign BUSY         = (state != IDLE) || !empty;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = PRESS;
        end
      end
      PRESS: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the held row answers, and only while its column is being strobed.
  always_comb begin
    row_nxt = '0;
    if (state == PRESS && COL[held[1:0]])
      row_nxt = 4'b0001 << held[3:2];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      held       <= '0;
      ROW        <= '0;
      PRESS_DONE <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ROW        <= row_nxt;
      PRESS_DONE <= done_nxt;
      if (pop) begin
        held   <= mem[rd_ptr];
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries data only; occupancy is tracked by count.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= KEY_IN;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: timeline reference model plus directed and random stimulus.
module tb_keypad_emulator;

  localparam int HOLD = 100;
  localparam int GAP  = 20;
`ifdef KEYPAD_EMULATOR_FIFO_EN
  localparam int QD = 4;
`else
  localparam int QD = 1;
`endif

  logic       CLK;
  logic       RST;
  logic [3:0] COL;
  logic [3:0] ROW;
  logic [3:0] KEY_IN;
  logic       KEY_IN_VALID;
  logic       KEY_IN_READY;
  logic       BUSY;
  logic       PRESS_DONE;

  keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .COL(COL), .ROW(ROW), .KEY_IN(KEY_IN),
    .KEY_IN_VALID(KEY_IN_VALID), .KEY_IN_READY(KEY_IN_READY),
    .BUSY(BUSY), .PRESS_DONE(PRESS_DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, got, exp);
    end
  endtask

  // Reference model: the key popped at edge p is pressed for edges p..p+HOLD-1,
  // released for the following GAP edges, and idle from edge p+HOLD+GAP on.
  longint     cyc = 0;
  longint     p = -1000000;
  logic [3:0] held = '0;
  logic [3:0] q[$];
  logic [3:0] exp_row = '0;
  logic       exp_done = 1'b0, exp_busy = 1'b0, exp_ready = 1'b1;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      p = -1000000;
      held = '0;
      exp_row = '0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      exp_ready = 1'b1;
    end else begin
      int sz;
      cyc++;
      sz = q.size();
      exp_row  = ((cyc - 1 >= p) && (cyc - 1 <= p + HOLD - 1) && COL[held[1:0]]) ?
                 (4'b0001 << held[3:2]) : 4'b0000;
      exp_done = (cyc == p + HOLD);
      if ((cyc - 1 >= p + HOLD + GAP) && sz > 0) begin
        held = q.pop_front();
        p = cyc;
      end
      if (KEY_IN_VALID && sz < QD) q.push_back(KEY_IN);
      exp_busy  = (cyc < p + HOLD + GAP) || (q.size() > 0);
      exp_ready = (q.size() < QD);
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("row", {28'b0, ROW}, {28'b0, exp_row});
      chk("press_done", {31'b0, PRESS_DONE}, {31'b0, exp_done});
      chk("busy", {31'b0, BUSY}, {31'b0, exp_busy});
      chk("ready", {31'b0, KEY_IN_READY}, {31'b0, exp_ready});
    end
  end

  // Column scanner: 0 = cycle one-hot every 16 clocks, 1 = random, 2 = fixed.
  int         col_mode = 0;
  int         col_cnt = 0;
  logic [3:0] col_fixed = '0;

  initial COL = '0;
  always @(negedge CLK) begin
    #3;
    case (col_mode)
      0:       COL = 4'b0001 << ((col_cnt / 16) % 4);
      1:       COL = 4'($urandom);
      default: COL = col_fixed;
    endcase
    col_cnt++;
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic push(input logic [3:0] k, output longint t);
    int n = 0;
    KEY_IN = k;
    KEY_IN_VALID = 1'b1;
    while (KEY_IN_READY !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    chk("push_ready", {31'b0, KEY_IN_READY}, 32'd1);
    step();
    t = cyc;
    KEY_IN_VALID = 1'b0;
    KEY_IN = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 2000) begin
      step();
      n++;
    end
    chk("idle_reached", {31'b0, BUSY}, 32'd0);
  endtask

  initial begin
    longint t, t2;
    int pulses, first, rows, busys;
    RST = 1'b0;
    KEY_IN = '0;
    KEY_IN_VALID = 1'b0;
    #1 RST = 1'b1;
    step();
    step();
    chk("reset_row", {28'b0, ROW}, 32'd0);
    chk("reset_busy", {31'b0, BUSY}, 32'd0);
    chk("reset_ready", {31'b0, KEY_IN_READY}, 32'd1);
    chk("reset_done", {31'b0, PRESS_DONE}, 32'd0);
    RST = 1'b0;
    chk_en = 1'b1;
    step();

    // Key 6 against a cycling scanner; one done pulse 101 clocks after acceptance.
    col_mode = 0;
    push(4'd6, t);
    pulses = 0;
    first = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (PRESS_DONE === 1'b1) begin
        pulses++;
        if (first < 0) first = int'(cyc - t);
      end
    end
    chk("done_latency", 32'(first), 32'd101);
    chk("done_pulses", 32'(pulses), 32'd1);

    // Key 13 with every column strobed, then none.
    wait_idle();
    col_mode = 2;
    col_fixed = 4'b1111;
    push(4'd13, t);
    while (cyc < t + 5) step();
    chk("all_cols_row", {28'b0, ROW}, 32'b1000);
    col_fixed = 4'b0000;
    step();
    chk("no_cols_row", {28'b0, ROW}, 32'd0);
    wait_idle();

    // Second key waits for the first to leave the queue.
    col_mode = 1;
    push(4'd3, t);
    push(4'd12, t2);
    chk("second_accept_delay", 32'(t2 - t), (QD == 1) ? 32'd2 : 32'd1);
    wait_idle();

    // Ordered presses of 0,5,10,15.
    col_mode = 0;
    push(4'd0, t);
    push(4'd5, t);
    push(4'd10, t);
    push(4'd15, t);
    wait_idle();

    // Continuous pushes while a press is running.
    col_mode = 1;
    push(4'd1, t);
    step();
    step();
    for (int i = 0; i < 5; i++) push(4'($urandom), t);
    wait_idle();

    // Reset in the middle of a press with keys queued.
    push(4'd9, t);
    for (int i = 0; i < ((QD >= 3) ? 2 : 1); i++) push(4'($urandom), t2);
    while (cyc < t + 51) step();
    col_mode = 2;
    col_fixed = 4'b1111;
    step();
    step();
    RST = 1'b1;
    #1;
    chk("rst_row_async", {28'b0, ROW}, 32'd0);
    step();
    step();
    RST = 1'b0;
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_ready", {31'b0, KEY_IN_READY}, 32'd1);
    pulses = 0;
    rows = 0;
    busys = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (PRESS_DONE !== 1'b0) pulses++;
      if (ROW !== 4'b0000) rows++;
      if (BUSY !== 1'b0) busys++;
    end
    chk("post_rst_done", 32'(pulses), 32'd0);
    chk("post_rst_row", 32'(rows), 32'd0);
    chk("post_rst_busy", 32'(busys), 32'd0);

    // Random traffic, including key changes while VALID is low and rare resets.
    col_mode = 1;
    for (int i = 0; i < 6000; i++) begin
      KEY_IN = 4'($urandom);
      KEY_IN_VALID = ($urandom_range(0, 5) == 0);
      RST = ($urandom_range(0, 1499) == 0);
      step();
    end
    RST = 1'b0;
    KEY_IN_VALID = 1'b0;
    wait_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
